// File: rtl/mc_ctrl_if.sv
// Control <-> datapath/memory bundle for the multi-cycle MIPS-lite controller.
// master = controller side, slave = datapath/memory side.
interface mc_ctrl_if #(parameter int ST_W = 3);
  logic [31:0]     ir;
  logic            zero;
  logic            mem_ack;
  logic            mem_req;
  logic            mem_we;
  logic            ir_wr;
  logic            pc_wr;
  logic            rf_wr;
  logic [1:0]      npc_op;
  logic [1:0]      wr_sel;
  logic [1:0]      wd_sel;
  logic [1:0]      b_sel;
  logic            ext_op;
  logic [2:0]      alu_op;
  logic [ST_W-1:0] state;

  modport master (
    input  ir, zero, mem_ack,
    output mem_req, mem_we, ir_wr, pc_wr, rf_wr,
           npc_op, wr_sel, wd_sel, b_sel, ext_op, alu_op, state
  );

  modport slave (
    output ir, zero, mem_ack,
    input  mem_req, mem_we, ir_wr, pc_wr, rf_wr,
           npc_op, wr_sel, wd_sel, b_sel, ext_op, alu_op, state
  );
endinterface

// File: rtl/mc_ctrl.sv
// Multi-cycle FETCH/DECODE/EXE/MEM/WB controller for the MIPS-lite datapath.
// Optional MC_CTRL_PERF_EN adds cycle and retired-instruction counters.
module mc_ctrl #(
  parameter int ST_W = 3
) (
  input  logic        clk,
  input  logic        reset,
  mc_ctrl_if.master   bus
`ifdef MC_CTRL_PERF_EN
  ,
  output logic [31:0] cyc_cnt,
  output logic [31:0] ins_cnt
`endif
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXE    = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_e;

  typedef enum logic [3:0] {
    I_NOP, I_ADDU, I_SUBU, I_JR, I_ORI, I_LUI, I_LW, I_SW, I_BEQ, I_J, I_JAL
  } instr_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUBU  = 6'h23;
  localparam logic [5:0] FN_JR    = 6'h08;

  state_e      state_q, state_d;
  instr_e      cls;
  logic [5:0]  op, fn;
  logic        unused_ir;

  logic        req_c, we_c, irw_c, pcw_c, rfw_c;
  logic [1:0]  npc_c, wr_c, wd_c, b_c;
  logic        ext_c;
  logic [2:0]  alu_c;

  assign op        = bus.ir[31:26];
  assign fn        = bus.ir[5:0];
  assign unused_ir = ^bus.ir[25:6];

  // Instruction class; anything not listed retires as a nop.
  always_comb begin
    cls = I_NOP;
    case (op)
      OP_RTYPE: begin
        case (fn)
          FN_ADDU: cls = I_ADDU;
          FN_SUBU: cls = I_SUBU;
          FN_JR:   cls = I_JR;
          default: cls = I_NOP;
        endcase
      end
      OP_ORI:  cls = I_ORI;
      OP_LUI:  cls = I_LUI;
      OP_LW:   cls = I_LW;
      OP_SW:   cls = I_SW;
      OP_BEQ:  cls = I_BEQ;
      OP_J:    cls = I_J;
      OP_JAL:  cls = I_JAL;
      default: cls = I_NOP;
    endcase
  end

  // Selects follow IR from DECODE on, so they stay stable for the whole
  // instruction; in FETCH (and hence in reset) IR is stale and they are 0.
  always_comb begin
    npc_c = 2'd0;
    wr_c  = 2'd0;
    wd_c  = 2'd0;
    b_c   = 2'd0;
    ext_c = 1'b0;
    alu_c = 3'd0;
    if (state_q != S_FETCH) begin
      case (cls)
        I_ADDU: begin wr_c = 2'd1; alu_c = 3'd0; end
        I_SUBU: begin wr_c = 2'd1; alu_c = 3'd1; end
        I_ORI:  begin b_c = 2'd1; ext_c = 1'b0; alu_c = 3'd2; end
        I_LUI:  begin b_c = 2'd1; alu_c = 3'd3; end
        I_LW:   begin wd_c = 2'd1; b_c = 2'd1; ext_c = 1'b1; end
        I_SW:   begin b_c = 2'd1; ext_c = 1'b1; end
        I_BEQ:  begin npc_c = bus.zero ? 2'd1 : 2'd0; alu_c = 3'd1; end
        I_J:    npc_c = 2'd2;
        I_JAL:  begin npc_c = 2'd2; wr_c = 2'd2; wd_c = 2'd2; end
        I_JR:   npc_c = 2'd3;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    req_c   = 1'b0;
    we_c    = 1'b0;
    irw_c   = 1'b0;
    pcw_c   = 1'b0;
    rfw_c   = 1'b0;
    case (state_q)
      S_FETCH: begin
        req_c = 1'b1;
        if (bus.mem_ack) begin
          irw_c   = 1'b1;
          state_d = S_DECODE;
        end
      end
      S_DECODE: state_d = S_EXE;
      S_EXE: begin
        case (cls)
          I_ADDU, I_SUBU, I_ORI, I_LUI: state_d = S_WB;
          I_LW, I_SW:                   state_d = S_MEM;
          I_JAL: begin
            pcw_c   = 1'b1;
            rfw_c   = 1'b1;
            state_d = S_FETCH;
          end
          default: begin
            pcw_c   = 1'b1;
            state_d = S_FETCH;
          end
        endcase
      end
      S_MEM: begin
        req_c = 1'b1;
        we_c  = (cls == I_SW);
        if (bus.mem_ack) begin
          if (cls == I_SW) begin
            pcw_c   = 1'b1;
            state_d = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end
      end
      S_WB: begin
        rfw_c   = 1'b1;
        pcw_c   = 1'b1;
        state_d = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
  end

  // Enables are qualified by reset so an abort never leaks a Mealy write.
  assign bus.mem_req = req_c;
  assign bus.mem_we  = we_c;
  assign bus.ir_wr   = irw_c & reset;
  assign bus.pc_wr   = pcw_c & reset;
  assign bus.rf_wr   = rfw_c & reset;
  assign bus.npc_op  = npc_c;
  assign bus.wr_sel  = wr_c;
  assign bus.wd_sel  = wd_c;
  assign bus.b_sel   = b_c;
  assign bus.ext_op  = ext_c;
  assign bus.alu_op  = alu_c;
  assign bus.state   = ST_W'(state_q);

`ifdef MC_CTRL_PERF_EN
  logic [31:0] cyc_q, ins_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cyc_q <= 32'd0;
      ins_q <= 32'd0;
    end else begin
      cyc_q <= cyc_q + 32'd1;
      ins_q <= ins_q + {31'd0, bus.pc_wr};
    end
  end

  assign cyc_cnt = cyc_q;
  assign ins_cnt = ins_q;
`endif

endmodule

// File: tb/tb_mc_ctrl.sv
// Self-checking bench for mc_ctrl: directed vector table, reset/abort
// sequences, and randomized instructions against an instruction-level model.
module tb_mc_ctrl;
  localparam int ST_W = 3;

  logic clk;
  logic reset;
  mc_ctrl_if #(.ST_W(ST_W)) bus();

`ifdef MC_CTRL_PERF_EN
  logic [31:0] cyc_cnt, ins_cnt;
  int          exp_cyc;
  int          exp_ins;
`endif

  mc_ctrl #(.ST_W(ST_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
`ifdef MC_CTRL_PERF_EN
    ,
    .cyc_cnt (cyc_cnt),
    .ins_cnt (ins_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef MC_CTRL_PERF_EN
  always @(posedge clk or negedge reset) begin
    if (!reset) exp_cyc <= 0;
    else        exp_cyc <= exp_cyc + 1;
  end
`endif

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Expected behaviour of one instruction (memory waits excluded from lat).
  typedef struct {
    int         lat;
    bit         mem;
    bit         we;
    logic [1:0] npc;
    int         rf;
    logic [1:0] wr;
    logic [1:0] wd;
    logic [1:0] b;
    logic       e;
    logic [2:0] alu;
  } exp_t;

  typedef struct {
    logic [31:0] ir;
    logic        zero;
    int          fw;
    int          mw;
    exp_t        ex;
  } vec_t;

  function automatic exp_t mk_exp(int lat, bit mem, bit we, logic [1:0] npc, int rf,
                                  logic [1:0] wr, logic [1:0] wd, logic [1:0] b,
                                  logic e, logic [2:0] alu);
    exp_t x;
    x.lat = lat; x.mem = mem; x.we = we; x.npc = npc; x.rf = rf;
    x.wr = wr; x.wd = wd; x.b = b; x.e = e; x.alu = alu;
    return x;
  endfunction

  function automatic vec_t mk_vec(logic [31:0] ir, logic zero, int fw, int mw, exp_t ex);
    vec_t v;
    v.ir = ir; v.zero = zero; v.fw = fw; v.mw = mw; v.ex = ex;
    return v;
  endfunction

  // Reference model: instruction table from the ISA subset.
  function automatic exp_t model(logic [31:0] ir, logic zero);
    logic [5:0] op;
    logic [5:0] fn;
    exp_t x;
    op = ir[31:26];
    fn = ir[5:0];
    x = mk_exp(3, 0, 0, 2'd0, 0, 2'd0, 2'd0, 2'd0, 1'b0, 3'd0);
    if (op == 6'h00 && fn == 6'h21) x = mk_exp(4, 0, 0, 2'd0, 1, 2'd1, 2'd0, 2'd0, 1'b0, 3'd0);
    if (op == 6'h00 && fn == 6'h23) x = mk_exp(4, 0, 0, 2'd0, 1, 2'd1, 2'd0, 2'd0, 1'b0, 3'd1);
    if (op == 6'h00 && fn == 6'h08) x.npc = 2'd3;
    if (op == 6'h0D) x = mk_exp(4, 0, 0, 2'd0, 1, 2'd0, 2'd0, 2'd1, 1'b0, 3'd2);
    if (op == 6'h0F) x = mk_exp(4, 0, 0, 2'd0, 1, 2'd0, 2'd0, 2'd1, 1'b0, 3'd3);
    if (op == 6'h23) x = mk_exp(5, 1, 0, 2'd0, 1, 2'd0, 2'd1, 2'd1, 1'b1, 3'd0);
    if (op == 6'h2B) x = mk_exp(4, 1, 1, 2'd0, 0, 2'd0, 2'd0, 2'd1, 1'b1, 3'd0);
    if (op == 6'h04) x = mk_exp(3, 0, 0, zero ? 2'd1 : 2'd0, 0, 2'd0, 2'd0, 2'd0, 1'b0, 3'd1);
    if (op == 6'h02) x.npc = 2'd2;
    if (op == 6'h03) x = mk_exp(3, 0, 0, 2'd2, 1, 2'd2, 2'd2, 2'd0, 1'b0, 3'd0);
    return x;
  endfunction

  // Runs one instruction from its first FETCH cycle; entered and left at a negedge.
  task automatic run(input string tag, input logic [31:0] ir, input logic zero,
                     input int fw, input int mw, input bit junk, input exp_t ex);
    int   cyc = 0, reqn = 0, wcnt = 0;
    int   irw_n = 0, irw_cyc = -1, rf_n = 0, req_n = 0, we_n = 0;
    bit   done = 0, unstable = 0;
    logic ack;
    logic [1:0] npc_s = '0, wr_s = '0, wd_s = '0, b_s = '0;
    logic e_s = 1'b0;
    logic [2:0] alu_s = '0;
    bus.ir   = ir;
    bus.zero = zero;
    while (!done && cyc < 64) begin
      if (bus.mem_req) ack = (wcnt == ((reqn == 0) ? fw : mw));
      else             ack = junk ? 1'($urandom_range(0, 1)) : 1'b0;
      bus.mem_ack = ack;
      #1;
      if (cyc == 0) begin
        chk({tag, ".fetch_state"}, 32'(bus.state), 32'd0);
        chk({tag, ".fetch_req"},   32'(bus.mem_req), 32'd1);
        chk({tag, ".fetch_we"},    32'(bus.mem_we), 32'd0);
      end
      if (bus.ir_wr) begin irw_n++; irw_cyc = cyc; end
      if (bus.mem_req) begin req_n++; if (bus.mem_we) we_n++; end
      if (bus.rf_wr) begin rf_n++; wr_s = bus.wr_sel; wd_s = bus.wd_sel; end
      if (irw_cyc >= 0 && cyc == irw_cyc + 1) begin
        b_s = bus.b_sel; e_s = bus.ext_op; alu_s = bus.alu_op;
      end else if (irw_cyc >= 0 && cyc > irw_cyc + 1 &&
                   (bus.b_sel !== b_s || bus.ext_op !== e_s || bus.alu_op !== alu_s)) begin
        unstable = 1;
      end
      if (bus.pc_wr) begin done = 1; npc_s = bus.npc_op; end
      cyc++;
      if (bus.mem_req) begin
        if (ack) begin reqn++; wcnt = 0; end
        else wcnt++;
      end
      @(negedge clk);
    end
    chk({tag, ".retired"}, 32'(done), 32'd1);
    chk({tag, ".cycles"},  32'(cyc), 32'(ex.lat + fw + (ex.mem ? mw : 0)));
    chk({tag, ".ir_wr_n"}, 32'(irw_n), 32'd1);
    chk({tag, ".ir_wr_at"}, 32'(irw_cyc), 32'(fw));
    chk({tag, ".req_cycles"}, 32'(req_n), 32'(fw + 1 + (ex.mem ? mw + 1 : 0)));
    chk({tag, ".we_cycles"}, 32'(we_n), 32'(ex.we ? mw + 1 : 0));
    chk({tag, ".npc_op"}, 32'(npc_s), 32'(ex.npc));
    chk({tag, ".rf_wr_n"}, 32'(rf_n), 32'(ex.rf));
    if (ex.rf != 0) begin
      chk({tag, ".wr_sel"}, 32'(wr_s), 32'(ex.wr));
      chk({tag, ".wd_sel"}, 32'(wd_s), 32'(ex.wd));
    end
    chk({tag, ".b_sel"},  32'(b_s), 32'(ex.b));
    chk({tag, ".ext_op"}, 32'(e_s), 32'(ex.e));
    chk({tag, ".alu_op"}, 32'(alu_s), 32'(ex.alu));
    chk({tag, ".sel_stable"}, 32'(unstable), 32'd0);
`ifdef MC_CTRL_PERF_EN
    if (done) exp_ins++;
    chk({tag, ".ins_cnt"}, ins_cnt, 32'(exp_ins));
    chk({tag, ".cyc_cnt"}, cyc_cnt, 32'(exp_cyc));
`endif
  endtask

  vec_t vecs[$];

  initial begin
    logic [5:0]  op_set [8];
    logic [5:0]  fn_set [3];
    logic [31:0] rir;
    logic        rz;
    int          pc_seen;

    op_set = '{6'h00, 6'h0D, 6'h0F, 6'h23, 6'h2B, 6'h04, 6'h02, 6'h03};
    fn_set = '{6'h21, 6'h23, 6'h08};

    //                ir            z  fw mw      lat mem we npc rf wr wd b  e  alu
    vecs.push_back(mk_vec(32'h00000000, 0, 0, 0, mk_exp(3, 0, 0, 0, 0, 0, 0, 0, 0, 0)));
    vecs.push_back(mk_vec(32'h34221234, 0, 2, 0, mk_exp(4, 0, 0, 0, 1, 0, 0, 1, 0, 2)));
    vecs.push_back(mk_vec(32'h8C410004, 0, 0, 1, mk_exp(5, 1, 0, 0, 1, 0, 1, 1, 1, 0)));
    vecs.push_back(mk_vec(32'hAC410008, 0, 0, 1, mk_exp(4, 1, 1, 0, 0, 0, 0, 1, 1, 0)));
    vecs.push_back(mk_vec(32'h10220003, 1, 0, 0, mk_exp(3, 0, 0, 1, 0, 0, 0, 0, 0, 1)));
    vecs.push_back(mk_vec(32'h10220003, 0, 0, 0, mk_exp(3, 0, 0, 0, 0, 0, 0, 0, 0, 1)));
    vecs.push_back(mk_vec(32'h0C000010, 0, 0, 0, mk_exp(3, 0, 0, 2, 1, 2, 2, 0, 0, 0)));
    vecs.push_back(mk_vec(32'h03E00008, 0, 1, 0, mk_exp(3, 0, 0, 3, 0, 0, 0, 0, 0, 0)));
    vecs.push_back(mk_vec(32'hFC000000, 0, 0, 0, mk_exp(3, 0, 0, 0, 0, 0, 0, 0, 0, 0)));
    vecs.push_back(mk_vec(32'h00221821, 0, 0, 0, mk_exp(4, 0, 0, 0, 1, 1, 0, 0, 0, 0)));
    vecs.push_back(mk_vec(32'h00221823, 0, 1, 0, mk_exp(4, 0, 0, 0, 1, 1, 0, 0, 0, 1)));
    vecs.push_back(mk_vec(32'h3C011234, 0, 0, 0, mk_exp(4, 0, 0, 0, 1, 0, 0, 1, 0, 3)));
    vecs.push_back(mk_vec(32'h08000010, 0, 0, 0, mk_exp(3, 0, 0, 2, 0, 0, 0, 0, 0, 0)));
    vecs.push_back(mk_vec(32'h8C410004, 0, 0, 0, mk_exp(5, 1, 0, 0, 1, 0, 1, 1, 1, 0)));
    vecs.push_back(mk_vec(32'hAC410008, 0, 3, 2, mk_exp(4, 1, 1, 0, 0, 0, 0, 1, 1, 0)));

    // Reset held 3 cycles with ack tied high: FETCH, request up, no writes.
    bus.ir = 32'h0; bus.zero = 1'b0; bus.mem_ack = 1'b1;
    reset = 1'b1;
    #1 reset = 1'b0;
`ifdef MC_CTRL_PERF_EN
    exp_ins = 0;
`endif
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      chk("rst.state", 32'(bus.state), 32'd0);
      chk("rst.mem_req", 32'(bus.mem_req), 32'd1);
      chk("rst.ir_wr", 32'(bus.ir_wr), 32'd0);
      chk("rst.pc_wr", 32'(bus.pc_wr), 32'd0);
      chk("rst.rf_wr", 32'(bus.rf_wr), 32'd0);
      chk("rst.sels", 32'({bus.npc_op, bus.wr_sel, bus.wd_sel, bus.b_sel, bus.ext_op, bus.alu_op}), 32'd0);
`ifdef MC_CTRL_PERF_EN
      chk("rst.cyc_cnt", cyc_cnt, 32'd0);
`endif
    end
    @(negedge clk);
    reset = 1'b1;

    foreach (vecs[i]) run($sformatf("vec%0d", i), vecs[i].ir, vecs[i].zero,
                          vecs[i].fw, vecs[i].mw, 1'b0, vecs[i].ex);

    // Abort an lw while MEM is waiting on ack.
    bus.ir = 32'h8C410004;
    for (int c = 0; c < 4; c++) begin
      bus.mem_ack = (c == 0);
      #1;
      if (c == 3) begin
        chk("abort.in_mem", 32'(bus.state), 32'd3);
        chk("abort.req", 32'(bus.mem_req), 32'd1);
      end
      if (c < 3) @(negedge clk);
    end
    reset = 1'b0;
    #1;
    chk("abort.state", 32'(bus.state), 32'd0);
    pc_seen = 0;
    for (int c = 0; c < 2; c++) begin
      bus.mem_ack = 1'b1;
      #1;
      if (bus.pc_wr || bus.rf_wr || bus.ir_wr) pc_seen++;
      @(negedge clk);
    end
    chk("abort.no_writes", 32'(pc_seen), 32'd0);
`ifdef MC_CTRL_PERF_EN
    exp_ins = 0;
    chk("abort.ins_clr", ins_cnt, 32'd0);
`endif
    reset = 1'b1;
    run("post_abort", 32'hFC000000, 1'b0, 0, 0, 1'b0, model(32'hFC000000, 1'b0));

    // Randomized instructions, waits and stray acks.
    for (int n = 0; n < 150; n++) begin
      rir = $urandom;
      if ($urandom_range(0, 7) != 0) rir[31:26] = op_set[$urandom_range(0, 7)];
      if (rir[31:26] == 6'h00 && $urandom_range(0, 5) != 0) rir[5:0] = fn_set[$urandom_range(0, 2)];
      rz = 1'($urandom_range(0, 1));
      run($sformatf("rnd%0d_%08h", n, rir), rir, rz, $urandom_range(0, 3),
          $urandom_range(0, 3), 1'($urandom_range(0, 1)), model(rir, rz));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
endmodule

// File: doc/mc_ctrl.md
Name: mc_ctrl

Overview:
- Multi-cycle control unit for the MIPS-lite datapath (PC, NPC, IR, RF, EXT, ALU, unified memory).
- Replaces the single-cycle combinational decoder with a state machine that sequences fetch, decode, execute, memory and writeback.
- Fetch and data accesses are issued over one shared req/ack memory port.
- Supported: addu, subu, ori, lui, lw, sw, beq, j, jal, jr; every other encoding executes as nop.

Parameters:
- ST_W, 3, width of the state register.

Ports:
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset (0 = reset)
- ir  in  32  instruction register contents (opcode ir[31:26], funct ir[5:0])
- zero  in  1  ALU zero flag, valid in EXE
- mem_ack  in  1  memory transfer complete this cycle
- mem_req  out  1  memory request, held until ack
- mem_we  out  1  store request (valid with mem_req)
- ir_wr  out  1  load IR from memory read data
- pc_wr  out  1  commit NPC into PC
- rf_wr  out  1  register file write
- npc_op  out  2  0 PC+4, 1 branch, 2 j/jal, 3 jr
- wr_sel  out  2  0 rt, 1 rd, 2 $31
- wd_sel  out  2  0 ALU, 1 memory data, 2 PC+4
- b_sel  out  2  0 rd2, 1 extended imm
- ext_op  out  1  0 zero-extend, 1 sign-extend
- alu_op  out  3  0 add, 1 sub, 2 or, 3 lui (B<<16)
- state  out  ST_W  current state, for debug

Behaviour:
- States: FETCH=0, DECODE=1, EXE=2, MEM=3, WB=4. Reset forces FETCH immediately and asynchronously.
- During reset, all enables (mem_req excepted) are 0 and all selects are 0.
- FETCH:
  - mem_req=1, mem_we=0.
  - When mem_ack=1: ir_wr=1 (same cycle, Mealy) and next state is DECODE; otherwise stay in FETCH.
- DECODE: always goes to EXE next; all enables are 0.
- EXE:
  - addu/subu/ori/lui go to WB.
  - lw/sw go to MEM.
  - beq: pc_wr=1, npc_op = zero ? 1 : 0, then FETCH.
  - j: pc_wr=1, npc_op=2, then FETCH.
  - jal: pc_wr=1, npc_op=2, rf_wr=1, wr_sel=2, wd_sel=2, then FETCH.
  - jr: pc_wr=1, npc_op=3, then FETCH.
  - nop/unknown: pc_wr=1, npc_op=0, then FETCH.
- MEM:
  - mem_req=1, mem_we=1 for sw and 0 for lw; stay in MEM until mem_ack.
  - sw on ack: pc_wr=1, npc_op=0, then FETCH.
  - lw on ack: go to WB.
- WB: rf_wr=1, pc_wr=1, npc_op=0, then FETCH.
  - addu: wr_sel=1, wd_sel=0, b_sel=0, alu_op=0.
  - subu: wr_sel=1, wd_sel=0, b_sel=0, alu_op=1.
  - ori: wr_sel=0, b_sel=1, ext_op=0, alu_op=2.
  - lui: wr_sel=0, b_sel=1, alu_op=3.
  - lw: wr_sel=0, wd_sel=1.
- Datapath selects (b_sel, ext_op, alu_op) are decoded from ir in every state from DECODE onward and held stable through the instruction. lw/sw use b_sel=1, ext_op=1, alu_op=0. beq uses b_sel=0, alu_op=1.
- Decode rules:
  - R-type is opcode 0x00 with funct 0x21 (addu), 0x23 (subu) or 0x08 (jr).
  - I/J opcodes: ori 0x0D, lui 0x0F, lw 0x23, sw 0x2B, beq 0x04, j 0x02, jal 0x03.
  - Any other opcode/funct pair, including 0x00000000, is nop.
- Handshake:
  - mem_req is asserted only in FETCH and MEM, and is held continuously until mem_ack.
  - mem_req falls the cycle after ack because the state changes.
  - mem_ack while mem_req=0 is ignored.
  - A zero-wait memory (ack in the same cycle as req) is legal.
- Every instruction asserts pc_wr exactly once. rf_wr is at most one cycle per instruction. ir_wr is exactly one cycle per instruction.
- Latency, excluding memory waits:
  - beq/j/jal/jr/nop: 3 cycles.
  - sw: 4 cycles.
  - ALU ops: 4 cycles.
  - lw: 5 cycles.
- Reset asserted mid-instruction (including while waiting on ack) aborts immediately: no pc_wr, rf_wr or ir_wr is issued. After release, the block restarts in FETCH.

Optional Feature:
- Macro MC_CTRL_PERF_EN.
- When defined, two extra outputs are added:
  - cyc_cnt (32): increments every cycle while out of reset.
  - ins_cnt (32): increments on every pc_wr.
  - Both clear on reset and wrap modulo 2^32.
- When undefined, neither port nor counter exists and behaviour is otherwise identical.

Test Plan:
- Reset low for 3 cycles, then high, ack tied 1 -> state=0, mem_req=1, mem_we=0, ir_wr=1 in the first cycle after release; no pc_wr/rf_wr during reset.
- ir=0x34221234 (ori $2,$1,0x1234), ack delayed 2 cycles in FETCH -> ir_wr in 3rd FETCH cycle; WB with rf_wr=1, wr_sel=0, b_sel=1, ext_op=0, alu_op=2, pc_wr=1; total 6 cycles.
- ir=0x8C410004 (lw) with MEM ack after 1 wait, then ir=0xAC410008 (sw) -> lw: MEM mem_we=0 then WB wd_sel=1, rf_wr=1; sw: MEM mem_we=1, pc_wr on ack, rf_wr never 1.
- ir=0x10220003 (beq) with zero=1, then again with zero=0 -> EXE pc_wr=1 with npc_op=1, then npc_op=0; 3 cycles each.
- ir=0x0C000010 (jal), then ir=0x03E00008 (jr $31) -> jal EXE: rf_wr=1, wr_sel=2, wd_sel=2, npc_op=2; jr EXE: npc_op=3, rf_wr=0.
- ir=0xFC000000 (unknown), and reset pulled low while in MEM waiting for ack -> nop retires in 3 cycles with npc_op=0; the reset case returns to FETCH with no pc_wr. With MC_CTRL_PERF_EN, ins_cnt equals the count of retired instructions.
